// File: rtl/fetch_unit_pkg.sv
// Shared types and select encodings for the LC-3b instruction fetch stage.
package fetch_unit_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } fetch_state_t;

  localparam lc3b_word LC3B_NOP = 16'h0000;

  // Next-fetch-address mux selects
  localparam logic [1:0] FA_INC   = 2'd0;
  localparam logic [1:0] FA_REDIR = 2'd1;
  localparam logic [1:0] FA_PEND  = 2'd2;

  // IF/ID instruction mux selects
  localparam logic [1:0] IR_NOP = 2'd0;
  localparam logic [1:0] IR_MEM = 2'd1;
  localparam logic [1:0] IR_BUF = 2'd2;

  function automatic lc3b_word align_pc(input lc3b_word a);
    return {a[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_ctrl.sv
// Fetch FSM: sequences the memory handshake, stall buffering and redirect squashing.
module fetch_unit_ctrl
  import fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall_i,
  input  logic       redirect_i,
  input  logic       imem_resp_i,
  output logic       imem_read_o,
  output logic       ifid_valid_o,
  output logic       fa_load_o,
  output logic [1:0] fa_sel_o,
  output logic       pend_load_o,
  output logic       irbuf_load_o,
  output logic [1:0] ir_sel_o
);

  fetch_state_t state_q, state_d;

  always_comb begin
    state_d      = state_q;
    imem_read_o  = 1'b0;
    ifid_valid_o = 1'b0;
    fa_load_o    = 1'b0;
    fa_sel_o     = FA_INC;
    pend_load_o  = 1'b0;
    irbuf_load_o = 1'b0;
    ir_sel_o     = IR_NOP;
    if (rst_n) begin
      unique case (state_q)
        FETCH: begin
          imem_read_o = 1'b1;
          if (imem_resp_i) begin
            if (redirect_i) begin
              fa_load_o = 1'b1;
              fa_sel_o  = FA_REDIR;
            end else begin
              ifid_valid_o = 1'b1;
              ir_sel_o     = IR_MEM;
              if (stall_i) begin
                irbuf_load_o = 1'b1;
                state_d      = HOLD;
              end else begin
                fa_load_o = 1'b1;
              end
            end
          end else if (redirect_i) begin
            // The read in flight cannot be cancelled; remember where to go.
            pend_load_o = 1'b1;
            state_d     = SQUASH;
          end
        end
        HOLD: begin
          if (redirect_i) begin
            fa_load_o = 1'b1;
            fa_sel_o  = FA_REDIR;
            state_d   = FETCH;
          end else begin
            ifid_valid_o = 1'b1;
            ir_sel_o     = IR_BUF;
            if (!stall_i) begin
              fa_load_o = 1'b1;
              state_d   = FETCH;
            end
          end
        end
        SQUASH: begin
          imem_read_o = 1'b1;
          if (imem_resp_i) begin
            fa_load_o = 1'b1;
            fa_sel_o  = redirect_i ? FA_REDIR : FA_PEND;
            state_d   = FETCH;
          end else if (redirect_i) begin
            pend_load_o = 1'b1;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/fetch_unit_reg.sv
// 16-bit load-enable register with synchronous active-low reset.
module fetch_unit_reg #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o
);

  logic [15:0] reg_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_q <= RESET_VAL;
    end else if (load_i) begin
      reg_q <= d_i;
    end
  end

  assign q_o = reg_q;

endmodule

// File: rtl/fetch_unit.sv
// LC-3b fetch stage top: fetch-address, pending-redirect and stall-buffer datapath.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic [15:0] imem_rdata,
  input  logic        imem_resp,
  output logic        ifid_load,
  output logic [15:0] ifid_pc,
  output logic [15:0] ifid_ir,
  output logic        ifid_valid
);

  logic       fa_load, pend_load, irbuf_load;
  logic [1:0] fa_sel, ir_sel;
  lc3b_word   fa_q, fa_d, pend_q, irbuf_q, target, fa_inc;

  fetch_unit_ctrl u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .imem_resp_i  (imem_resp),
    .imem_read_o  (imem_read),
    .ifid_valid_o (ifid_valid),
    .fa_load_o    (fa_load),
    .fa_sel_o     (fa_sel),
    .pend_load_o  (pend_load),
    .irbuf_load_o (irbuf_load),
    .ir_sel_o     (ir_sel)
  );

  assign target = align_pc(redirect_pc);
  assign fa_inc = fa_q + 16'd2;

  always_comb begin
    fa_d = fa_inc;
    unique case (fa_sel)
      FA_REDIR: fa_d = target;
      FA_PEND:  fa_d = pend_q;
      default:  fa_d = fa_inc;
    endcase
  end

  fetch_unit_reg #(.RESET_VAL(RESET_PC)) u_fa (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (fa_load),
    .d_i    (fa_d),
    .q_o    (fa_q)
  );

  fetch_unit_reg #(.RESET_VAL(16'h0000)) u_pend (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (pend_load),
    .d_i    (target),
    .q_o    (pend_q)
  );

  fetch_unit_reg #(.RESET_VAL(16'h0000)) u_irbuf (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (irbuf_load),
    .d_i    (imem_rdata),
    .q_o    (irbuf_q)
  );

  assign imem_address = fa_q;
  assign ifid_load    = rst_n & ~stall;
  // During reset fa_q may not yet hold RESET_PC, so the PC is forced.
  assign ifid_pc      = rst_n ? fa_inc : RESET_PC + 16'd2;

  always_comb begin
    ifid_ir = LC3B_NOP;
    unique case (ir_sel)
      IR_MEM:  ifid_ir = imem_rdata;
      IR_BUF:  ifid_ir = irbuf_q;
      default: ifid_ir = LC3B_NOP;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural fetch model plus variable-latency memory.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_resp = 1'b0;
  logic        ifid_load;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_ir;
  logic        ifid_valid;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .ifid_load    (ifid_load),
    .ifid_pc      (ifid_pc),
    .ifid_ir      (ifid_ir),
    .ifid_valid   (ifid_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the fetch stage
  logic [15:0] m_fa = RESET_PC;
  logic [15:0] m_pend = 16'h0000;
  logic [15:0] m_buf = 16'h0000;
  bit          m_holding = 1'b0;   // an instruction is parked waiting for stall to drop
  bit          m_discard = 1'b0;   // the read in flight belongs to a squashed path

  // Memory model
  bit mem_busy = 1'b0;
  int mem_cnt = 0;
  int mem_lat = 0;
  int lat_cfg = 0;                 // negative: random latency per request

  // Last sampled DUT outputs, for hand-computed literal checks
  logic        obs_read, obs_valid, obs_load;
  logic [15:0] obs_addr, obs_ir, obs_pc;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0002) return 16'h5678;
    return a ^ 16'h3C5A;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, answer memory, compare against the model, advance.
  task automatic cycle(input logic r, input logic s, input logic rd, input logic [15:0] rpc);
    logic        e_read, e_valid, e_load;
    logic [15:0] e_ir, e_pc, tgt;
    rst_n = r; stall = s; redirect = rd; redirect_pc = rpc;
    tgt = {rpc[15:1], 1'b0};
    #1;
    imem_resp = 1'b0;
    imem_rdata = 16'($urandom);
    if (!r) begin
      mem_busy = 1'b0;
    end else if (imem_read) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt = 0;
        mem_lat = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 3));
      end
      imem_resp = (mem_cnt == mem_lat);
      if (imem_resp) imem_rdata = mem_word(imem_address);
    end
    #1;
    e_read = r && !m_holding;
    e_load = r && !s;
    e_valid = 1'b0;
    e_ir = 16'h0000;
    e_pc = r ? m_fa + 16'd2 : RESET_PC + 16'd2;
    if (r && !rd) begin
      if (m_holding) begin
        e_valid = 1'b1; e_ir = m_buf;
      end else if (!m_discard && imem_resp) begin
        e_valid = 1'b1; e_ir = imem_rdata;
      end
    end
    chk("imem_read", {15'd0, imem_read}, {15'd0, e_read});
    if (e_read) chk("imem_address", imem_address, m_fa);
    chk("ifid_load", {15'd0, ifid_load}, {15'd0, e_load});
    chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, e_valid});
    chk("ifid_ir", ifid_ir, e_ir);
    chk("ifid_pc", ifid_pc, e_pc);
    obs_read = imem_read; obs_valid = ifid_valid; obs_load = ifid_load;
    obs_addr = imem_address; obs_ir = ifid_ir; obs_pc = ifid_pc;
    if (ifid_load && ifid_valid)
      $display("deliver t=%0t pc=%h ir=%h", $time, ifid_pc, ifid_ir);
    @(posedge clk);
    if (!r) begin
      m_fa = RESET_PC; m_pend = 16'h0000; m_buf = 16'h0000;
      m_holding = 1'b0; m_discard = 1'b0;
    end else if (m_holding) begin
      if (rd) begin m_fa = tgt; m_holding = 1'b0; end
      else if (!s) begin m_fa = m_fa + 16'd2; m_holding = 1'b0; end
    end else if (m_discard) begin
      if (imem_resp) begin m_fa = rd ? tgt : m_pend; m_discard = 1'b0; end
      else if (rd) m_pend = tgt;
    end else if (imem_resp) begin
      if (rd) m_fa = tgt;
      else if (s) begin m_buf = imem_rdata; m_holding = 1'b1; end
      else m_fa = m_fa + 16'd2;
    end else if (rd) begin
      m_pend = tgt; m_discard = 1'b1;
    end
    if (r && mem_busy) begin
      if (imem_resp) mem_busy = 1'b0;
      else mem_cnt++;
    end
    #1;
  endtask

  initial begin
    @(posedge clk); #1;
    lat_cfg = 0;
    // Reset behaviour
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    chk("rst_read", {15'd0, obs_read}, 16'h0000);
    chk("rst_pc", obs_pc, 16'h0002);
    // Zero-latency back-to-back fetches
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    chk("f0_addr", obs_addr, 16'h0000);
    chk("f0_ir", obs_ir, 16'h1234);
    chk("f0_pc", obs_pc, 16'h0002);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    chk("f1_ir", obs_ir, 16'h5678);
    chk("f1_pc", obs_pc, 16'h0004);
    chk("f1_valid", {15'd0, obs_valid}, 16'h0001);
    // Stall buffering at 0x0010
    cycle(1'b1, 1'b0, 1'b1, 16'h0010);
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      chk("hold_read", {15'd0, obs_read}, 16'h0000);
      chk("hold_ir", obs_ir, mem_word(16'h0010));
    end
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    chk("hold_deliver_pc", obs_pc, 16'h0012);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    chk("after_hold_addr", obs_addr, 16'h0012);
    // Redirect during a 3-cycle read at 0x0020
    cycle(1'b1, 1'b0, 1'b1, 16'h0020);
    lat_cfg = 3;
    cycle(1'b1, 1'b0, 1'b1, 16'h0101);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0);
      chk("squash_addr", obs_addr, 16'h0020);
      chk("squash_valid", {15'd0, obs_valid}, 16'h0000);
    end
    // Two redirects during one outstanding read
    cycle(1'b1, 1'b0, 1'b1, 16'h0040);
    chk("redir_target", obs_addr, 16'h0100);
    cycle(1'b1, 1'b0, 1'b1, 16'h0060);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    chk("last_redir_wins", obs_addr, 16'h0060);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0);
    // Redirect together with resp at 0x0030
    lat_cfg = 0;
    cycle(1'b1, 1'b0, 1'b1, 16'h0030);
    cycle(1'b1, 1'b0, 1'b1, 16'h0077);
    chk("rr_addr", obs_addr, 16'h0030);
    chk("rr_valid", {15'd0, obs_valid}, 16'h0000);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    chk("rr_next", obs_addr, 16'h0076);
    // Address wrap
    cycle(1'b1, 1'b0, 1'b1, 16'hFFFE);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    chk("wrap_addr", obs_addr, 16'hFFFE);
    chk("wrap_pc", obs_pc, 16'h0000);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    chk("wrap_next", obs_addr, 16'h0000);
    // Reset while squashing
    lat_cfg = 3;
    cycle(1'b1, 1'b0, 1'b1, 16'h0200);
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    chk("sq_rst_read", {15'd0, obs_read}, 16'h0000);
    chk("sq_rst_load", {15'd0, obs_load}, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    chk("sq_rst_resume", obs_addr, RESET_PC);
    chk("sq_rst_req", {15'd0, obs_read}, 16'h0001);
    // Randomized traffic
    lat_cfg = -1;
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 15),
            16'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
